// File: rtl/mic1_unshift_seq_if.sv
// Handshake bundle for the MIC-1 reverse shifter: operand/SET in, result out.
interface mic1_unshift_seq_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] Data_in;
    logic [1:0]       SET;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] Unshift_out;
    logic             Out_valid;
    logic             Out_ready;
    logic             Busy;

    modport master (
        output Data_in, SET, In_valid, Out_ready,
        input  In_ready, Unshift_out, Out_valid, Busy
    );

    modport slave (
        input  Data_in, SET, In_valid, Out_ready,
        output In_ready, Unshift_out, Out_valid, Busy
    );
endinterface

// File: rtl/mic1_unshift_seq.sv
// Multi-cycle reverse shifter (SRL8 / SLL1), one step per clock, valid/ready on both sides.
// Define MIC1_UNSHIFT_BYTE_STEP_EN to do SRL8 as a single byte-wide step.
module mic1_unshift_seq #(
    parameter int WIDTH = 32
) (
    input  logic              CLK,
    input  logic              RST,
    mic1_unshift_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] d;
    logic [3:0]       cnt;
    logic [1:0]       set_q;

    function automatic logic [3:0] steps(input logic [1:0] set);
        case (set)
`ifdef MIC1_UNSHIFT_BYTE_STEP_EN
            2'b01:   steps = 4'd1;
`else
            2'b01:   steps = 4'd8;
`endif
            2'b10:   steps = 4'd1;
            default: steps = 4'd0;
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            d     <= '0;
            cnt   <= '0;
            set_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.In_valid) begin
                        d     <= bus.Data_in;
                        set_q <= bus.SET;
                        cnt   <= steps(bus.SET);
                        state <= (steps(bus.SET) == 4'd0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    // Only SRL8 and SLL1 ever reach SHIFT; zero fill in both directions.
                    if (set_q == 2'b01) begin
`ifdef MIC1_UNSHIFT_BYTE_STEP_EN
                        d <= {8'h00, d[WIDTH-1:8]};
`else
                        d <= {1'b0, d[WIDTH-1:1]};
`endif
                    end else begin
                        d <= {d[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE: begin
                    if (bus.Out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Unshift_out = d;
    assign bus.In_ready    = (state == IDLE);
    assign bus.Busy        = (state != IDLE);
    assign bus.Out_valid   = (state == DONE);
endmodule

// File: tb/tb_mic1_unshift_seq.sv
// Directed table-driven bench for mic1_unshift_seq plus backpressure and reset-abort sequences.
module tb_mic1_unshift_seq;
    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    mic1_unshift_seq_if #(.WIDTH(32)) bus ();
    mic1_unshift_seq #(.WIDTH(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

`ifdef MIC1_UNSHIFT_BYTE_STEP_EN
    localparam int K_SRL8 = 1;
`else
    localparam int K_SRL8 = 8;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  set;
        logic [31:0] exp;
        int          k;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Accept one operation, scramble the pins during the run, and check result and latency.
    task automatic run_op(input logic [31:0] data, input logic [1:0] set,
                          input logic [31:0] exp, input int k, input bit bp);
        int n;
        @(negedge CLK);
        chk("in_ready_before_accept", {31'd0, bus.In_ready}, 32'd1);
        bus.Data_in   = data;
        bus.SET       = set;
        bus.In_valid  = 1'b1;
        bus.Out_ready = !bp;
        @(posedge CLK);
        @(negedge CLK);
        bus.In_valid = 1'b0;
        bus.Data_in  = $urandom;
        bus.SET      = ~set;
        n = 0;
        while (!bus.Out_valid && n < 40) begin
            @(negedge CLK);
            n++;
        end
        chk("latency", n, k);
        chk("result", bus.Unshift_out, exp);
        chk("busy_in_done", {31'd0, bus.Busy}, 32'd1);
        chk("in_ready_in_done", {31'd0, bus.In_ready}, 32'd0);
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                if (i == 0) begin
                    bus.In_valid = 1'b1;
                    bus.SET      = 2'b10;
                    bus.Data_in  = 32'h1;
                end else begin
                    bus.In_valid = 1'b0;
                end
                @(negedge CLK);
                chk("bp_out_valid", {31'd0, bus.Out_valid}, 32'd1);
                chk("bp_result_stable", bus.Unshift_out, exp);
                chk("bp_in_ready", {31'd0, bus.In_ready}, 32'd0);
            end
            bus.Out_ready = 1'b1;
        end
        @(negedge CLK);
        chk("in_ready_after_done", {31'd0, bus.In_ready}, 32'd1);
        chk("out_valid_after_done", {31'd0, bus.Out_valid}, 32'd0);
        chk("busy_after_done", {31'd0, bus.Busy}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 32'h8000_1234, set: 2'b01, exp: 32'h0080_0012, k: K_SRL8};
        vecs[1] = '{data: 32'hC000_0001, set: 2'b10, exp: 32'h8000_0002, k: 1};
        vecs[2] = '{data: 32'hDEAD_BEEF, set: 2'b00, exp: 32'hDEAD_BEEF, k: 0};
        vecs[3] = '{data: 32'h0000_FFFF, set: 2'b11, exp: 32'h0000_FFFF, k: 0};
        vecs[4] = '{data: 32'hFFFF_FFFF, set: 2'b01, exp: 32'h00FF_FFFF, k: K_SRL8};
        vecs[5] = '{data: 32'h8000_0000, set: 2'b10, exp: 32'h0000_0000, k: 1};

        bus.Data_in   = '0;
        bus.SET       = '0;
        bus.In_valid  = 1'b0;
        bus.Out_ready = 1'b1;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_out", bus.Unshift_out, 32'h0);
        chk("rst_out_valid", {31'd0, bus.Out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.In_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        RST = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].data, vecs[i].set, vecs[i].exp, vecs[i].k, 1'b0);

        // Backpressure in DONE with an ignored In_valid pulse.
        run_op(32'h0000_0004, 2'b10, 32'h0000_0008, 1, 1'b1);

        // Abort mid-SRL8, then a normal operation.
        @(negedge CLK);
        bus.Data_in  = 32'hFFFF_FFFF;
        bus.SET      = 2'b01;
        bus.In_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.In_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        chk("abort_out", bus.Unshift_out, 32'h0);
        chk("abort_out_valid", {31'd0, bus.Out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, bus.In_ready}, 32'd1);
        chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        run_op(32'h0000_0004, 2'b10, 32'h0000_0008, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mic1_unshift_seq.md
# mic1_unshift_seq

Multi-cycle reverse shifter for the MIC-1 datapath. It undoes the two non-trivial shifter operations: logical right by 8 (recovers the byte placed by SLL8) and left by 1 (reverses SRA1). It runs one bit position per clock under a valid/ready handshake on both sides. It sits between the C-bus register file and the ALU B-input path, and is used by microcode that must unpack bytes or restore halved values.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (the SRL8 count is fixed).
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- Data_in  in  WIDTH  operand, sampled on accept.
- SET  in  2  operation code, sampled on accept: 00 pass, 01 SRL8, 10 SLL1, 11 pass.
- In_valid  in  1  operand and SET are valid.
- In_ready  out  1  block can accept; high only in IDLE.
- Unshift_out  out  WIDTH  result register; meaningful only while Out_valid=1.
- Out_valid  out  1  result available; high only in DONE.
- Out_ready  in  1  consumer takes the result.
- Busy  out  1  high in SHIFT or DONE.

## Operation
- Three states: IDLE, SHIFT, DONE. There is a data register D (WIDTH bits) and a step counter C (4 bits).
- Accept condition: In_valid & In_ready at a rising edge.
  - D ← Data_in.
  - C ← k, where k = 0 for SET 00/11, 8 for SET 01, 1 for SET 10.
  - Next state is DONE if k=0, otherwise SHIFT.
- SHIFT, one step per edge:
  - SET 01: D ← {1'b0, D[31:1]}. Zero fill, never sign fill.
  - SET 10: D ← {D[30:0], 1'b0}.
  - C ← C-1. When C transitions 1→0, next state is DONE.
- The latched SET is held internally. Changes on the SET or Data_in pins outside the accept edge have no effect.
- DONE: Out_valid=1. D and Out_valid stay stable until Out_ready=1 at an edge, then the next state is IDLE.
- In_valid while not IDLE is ignored. No accept is possible in the same cycle as an output transfer, because In_ready=0 in DONE.
- Out_ready while not in DONE is ignored.
- Unshift_out = D directly; there is no combinational path from Data_in.
- In_ready = (state==IDLE). Busy = !In_ready. Out_valid = (state==DONE).

## Timing
- Reset values (asserted asynchronously, held while RST=1):
  - state = IDLE, D = 0, C = 0.
  - Unshift_out = 0x0000_0000, Out_valid = 0, In_ready = 1, Busy = 0.
- Let E0 be the accept edge. Out_valid is first high in the cycle after edge E0+k.
  - Pass (SET 00/11): result visible the cycle after E0.
  - SLL1: one cycle later than pass.
  - SRL8: eight cycles later than pass.
- Throughput without backpressure: one operation per k+2 cycles (accept, k shifts, one DONE cycle, one IDLE cycle).
- Reset mid-operation (SHIFT or DONE): the operation is aborted immediately. It is not completed and produces no partial Out_valid. The first accept after RST deasserts behaves normally.
- RST deasserts synchronously to CLK externally. The block adds no reset synchronizer.

## Configuration
- MIC1_UNSHIFT_BYTE_STEP_EN defined:
  - SET 01 loads k=1 and its single SHIFT step is D ← {8'h00, D[31:8]}, so SRL8 latency equals SLL1 latency.
  - SET 10 and pass are unchanged.
- Undefined: the bit-serial behaviour above, with k=8 for SRL8.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- SRL8 zero fill: after reset, Data_in=0x8000_1234, SET=01, In_valid pulse → Unshift_out=0x0080_0012 with Out_valid first high the cycle after edge E0+8. Bit 31 of the result is 0.
- SLL1: Data_in=0xC000_0001, SET=10 → 0x8000_0002 the cycle after edge E0+1.
- Pass: SET=00 with 0xDEAD_BEEF, then SET=11 with 0x0000_FFFF → each echoed the cycle after E0. Busy high for exactly one cycle per operation with Out_ready held 1.
- Backpressure: hold Out_ready=0 for 5 cycles in DONE → Out_valid=1 and Unshift_out are stable, In_ready=0, and a new In_valid pulse (SET=10, 0x1) is ignored. Releasing Out_ready gives IDLE next cycle, with In_ready=1.
- Reset mid-shift: SRL8 on 0xFFFF_FFFF, assert RST after 3 SHIFT edges → all outputs are at reset values immediately. Then SET=10 on 0x0000_0004 yields 0x0000_0008.
- Build with MIC1_UNSHIFT_BYTE_STEP_EN: SRL8 of 0x8000_1234 → 0x0080_0012 the cycle after edge E0+1.
